wb_arbiter_2m: RTL and testbench
================================

Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone classic arbiter that lets the pipeline's fetch master (IF) and data master (MEM) share a single bus to the SRAM/peripheral interconnect.
- Bus ownership is held for a whole cyc_o assertion, so one master's transaction is never interleaved with the other's.
- Round-robin fairness with a bus watchdog that aborts a transaction that gets no acknowledge.
- Sits between the CPU master's two Wishbone ports and the shared slave bus.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; select width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 255, cycles a strobe may wait without ack before abort; legal range 2..65535; counter is 16 bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  in  1 each  master 0 (IF) cycle, strobe, write enable.
- m0_wb_adr_i  in  ADDR_WIDTH  master 0 address.
- m0_wb_dat_i  in  DATA_WIDTH  master 0 write data.
- m0_wb_sel_i  in  DATA_WIDTH/8  master 0 byte select.
- m0_wb_dat_o  out  DATA_WIDTH  read data to master 0.
- m0_wb_ack_o, m0_wb_err_o  out  1 each  ack / abort to master 0.
- m1_wb_*  same set as m0_wb_*  master 1 (MEM).
- s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  out  1 each  slave bus control.
- s_wb_adr_o  out  ADDR_WIDTH  slave address.
- s_wb_dat_o  out  DATA_WIDTH  slave write data.
- s_wb_sel_o  out  DATA_WIDTH/8  slave byte select.
- s_wb_dat_i  in  DATA_WIDTH  slave read data.
- s_wb_ack_i  in  1  slave acknowledge.
- grant_o  out  2  one-hot current owner; bit0 = m0, bit1 = m1; 00 when idle.
- timeout_flag_o  out  1  sticky; set on any watchdog abort.

Behaviour:
- States: IDLE, OWN0, OWN1. Registered, with a last_owner bit.
- Reset (reset==0 at clk edge):
  - state=IDLE, last_owner=0 (so m1 wins the first tie), watchdog=0, timeout_flag_o=0.
  - All s_wb_* control outputs 0; all m*_ack/err 0; grant_o=00.
- Arbitration function, evaluated in IDLE or on owner release:
  - Request = mX_wb_cyc_i.
  - Only one requester: it wins.
  - Both requesting: the master that is not last_owner wins.
- Transitions:
  - IDLE with a request: go to OWNx next cycle. Grant latency is 1 cycle; slave sees stb the cycle after the request.
  - OWNx with mx_cyc_i=1: stay.
  - OWNx with mx_cyc_i=0: re-arbitrate in the same cycle and go to OWNy or IDLE. Handover costs no idle cycle. The slave sees cyc=0 during the release cycle.
  - Entering OWNx sets last_owner=x.
- Muxing, combinational from state:
  - In OWNx, s_wb_* = mx_wb_*, and mx_wb_ack_o = s_wb_ack_i.
  - The non-owner gets ack=0 and err=0.
  - Both mX_wb_dat_o = s_wb_dat_i at all times.
  - In IDLE, s_wb_cyc_o = s_wb_stb_o = 0 and the other s_wb_* outputs are 0.
- Watchdog:
  - In OWNx, increments while s_wb_stb_o=1 and s_wb_ack_i=0.
  - Clears on ack, on state change, or when the owner's stb is 0.
  - When the count equals TIMEOUT_CYCLES-1 and ack is still 0, the next cycle is the abort cycle:
    - mx_wb_err_o=1 for exactly 1 cycle.
    - s_wb_cyc_o and s_wb_stb_o are forced to 0.
    - timeout_flag_o is set.
    - State goes to IDLE, and last_owner stays x.
  - If ack arrives in the same cycle the watchdog would fire, ack wins and no err is raised.
- Simultaneous events:
  - A request from the non-owner while the owner holds cyc is ignored until release.
  - A slave ack in IDLE is dropped; no master sees it.
- Reset mid-transaction: outputs drop immediately at the edge and no ack/err is delivered.

Test Plan:
- Single master: m0 reads 0x8000_0000 and slave acks 2 cycles after stb -> grant_o=01 one cycle after m0_cyc; m0_ack pulses once with slave data 0x1234_5678; grant_o=00 after m0 drops cyc.
- Tie after reset: m0 and m1 raise cyc in the same cycle -> m1 granted first (grant_o=10); on m1 release, m0 granted the very next cycle (grant_o=01) with no idle cycle.
- Fairness: both hold continuous back-to-back requests over 6 transactions -> grants strictly alternate m1, m0, m1, m0, m1, m0.
- Ownership hold: m1 holds cyc across 3 strobes while m0 requests -> m0 is not granted until m1's cyc falls; m0's ack stays 0 throughout.
- Watchdog, TIMEOUT_CYCLES=4: m0 strobes and slave never acks -> m0_err pulses exactly once on the 5th strobe cycle, s_wb_cyc_o=0 that cycle, timeout_flag_o=1 and stays 1; ack on exactly the 4th cycle -> no err.
- Reset (reset=0) during an OWN1 write -> s_wb_cyc_o=0 next edge, grant_o=00, timeout_flag_o cleared; a subsequent tie is again won by m1.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter with round-robin and a no-ack watchdog.
// Latency: grant one cycle after cyc rises; data/ack paths combinational from state.
// Backpressure: the non-owner waits for the owner's cyc to drop; stalled strobes abort after TIMEOUT_CYCLES.
module wb_arbiter_2m #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_err_o,
  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_err_o,
  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  input  logic                    s_wb_ack_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_flag_o
);

  // Watchdog fires when the count has reached this value with no ack.
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t      state, state_nxt, arb_pick;
  logic        last_owner, last_owner_nxt;
  logic        abort_q, abort_nxt;
  logic [15:0] wdog, wdog_nxt;

  // Arbitration: single requester wins; on a tie the master that did not own last wins.
  always_comb begin
    arb_pick = IDLE;
    if (m0_wb_cyc_i && m1_wb_cyc_i) begin
      arb_pick = last_owner ? OWN0 : OWN1;
    end else if (m1_wb_cyc_i) begin
      arb_pick = OWN1;
    end else if (m0_wb_cyc_i) begin
      arb_pick = OWN0;
    end
  end

  // Next state: hold while the owner keeps cyc, hand over in the release cycle, abort on watchdog.
  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    case (state)
      IDLE: state_nxt = arb_pick;
      OWN0: begin
        if (abort_q) begin
          state_nxt = IDLE;
        end else if (!m0_wb_cyc_i) begin
          state_nxt = arb_pick;
        end else if (s_wb_stb_o && !s_wb_ack_i && wdog == WD_LIMIT) begin
          abort_nxt = 1'b1;
        end
      end
      OWN1: begin
        if (abort_q) begin
          state_nxt = IDLE;
        end else if (!m1_wb_cyc_i) begin
          state_nxt = arb_pick;
        end else if (s_wb_stb_o && !s_wb_ack_i && wdog == WD_LIMIT) begin
          abort_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counts stalled strobe cycles; last_owner records each new grant.
  always_comb begin
    wdog_nxt       = wdog + 16'd1;
    last_owner_nxt = last_owner;
    if (state_nxt != state || abort_q || abort_nxt || s_wb_ack_i || !s_wb_stb_o) begin
      wdog_nxt = '0;
    end
    if (state_nxt == OWN0 && state != OWN0) begin
      last_owner_nxt = 1'b0;
    end else if (state_nxt == OWN1 && state != OWN1) begin
      last_owner_nxt = 1'b1;
    end
  end

  // State, watchdog and sticky timeout flag registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      last_owner     <= 1'b0;
      abort_q        <= 1'b0;
      wdog           <= '0;
      timeout_flag_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      abort_q    <= abort_nxt;
      wdog       <= wdog_nxt;
      if (abort_nxt) begin
        timeout_flag_o <= 1'b1;
      end
    end
  end

  // Bus mux: owner drives the slave; the abort cycle kills cyc/stb and signals err instead of ack.
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    grant_o     = 2'b00;
    case (state)
      OWN0: begin
        grant_o     = 2'b01;
        s_wb_cyc_o  = m0_wb_cyc_i && !abort_q;
        s_wb_stb_o  = m0_wb_stb_i && !abort_q;
        s_wb_we_o   = m0_wb_we_i;
        s_wb_adr_o  = m0_wb_adr_i;
        s_wb_dat_o  = m0_wb_dat_i;
        s_wb_sel_o  = m0_wb_sel_i;
        m0_wb_ack_o = s_wb_ack_i && !abort_q;
        m0_wb_err_o = abort_q;
      end
      OWN1: begin
        grant_o     = 2'b10;
        s_wb_cyc_o  = m1_wb_cyc_i && !abort_q;
        s_wb_stb_o  = m1_wb_stb_i && !abort_q;
        s_wb_we_o   = m1_wb_we_i;
        s_wb_adr_o  = m1_wb_adr_i;
        s_wb_dat_o  = m1_wb_dat_i;
        s_wb_sel_o  = m1_wb_sel_i;
        m1_wb_ack_o = s_wb_ack_i && !abort_q;
        m1_wb_err_o = abort_q;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the ack qualifies it.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: per-cycle vector table with a read-data scoreboard.
// Latency: vectors drive 1 time unit after posedge and sample 1 unit later.
// Backpressure: none; the bench plays both masters and the slave.
module tb_wb_arbiter_2m;

  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h4000_0010;
  localparam logic [31:0] W0 = 32'hAAAA_0000;
  localparam logic [31:0] W1 = 32'hBBBB_1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i;
  logic [31:0] m0_wb_adr_i, m0_wb_dat_i, m0_wb_dat_o;
  logic [3:0]  m0_wb_sel_i;
  logic        m0_wb_ack_o, m0_wb_err_o;
  logic        m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i;
  logic [31:0] m1_wb_adr_i, m1_wb_dat_i, m1_wb_dat_o;
  logic [3:0]  m1_wb_sel_i;
  logic        m1_wb_ack_o, m1_wb_err_o;
  logic        s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
  logic [31:0] s_wb_adr_o, s_wb_dat_o, s_wb_dat_i;
  logic [3:0]  s_wb_sel_o;
  logic        s_wb_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_flag_o;

  wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
    .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_sel_i(m0_wb_sel_i),
    .m0_wb_dat_o(m0_wb_dat_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
    .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_sel_i(m1_wb_sel_i),
    .m1_wb_dat_o(m1_wb_dat_o), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
    .s_wb_cyc_o(s_wb_cyc_o), .s_wb_stb_o(s_wb_stb_o), .s_wb_we_o(s_wb_we_o),
    .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_sel_o(s_wb_sel_o),
    .s_wb_dat_i(s_wb_dat_i), .s_wb_ack_i(s_wb_ack_i),
    .grant_o(grant_o), .timeout_flag_o(timeout_flag_o)
  );

  always #5 clk = ~clk;

  // in  = {reset, m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
  // ex  = {grant[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, timeout_flag}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] dat;
    logic [8:0]  ex;
  } vec_t;

  typedef struct {
    logic        who;
    logic [31:0] dat;
  } sb_t;

  vec_t vq[$];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(input logic [5:0] in, input logic [31:0] dat, input logic [8:0] ex);
    vec_t v;
    v.in  = in;
    v.dat = dat;
    v.ex  = ex;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
    end
  endtask

  // Scoreboard side: every ack seen by a master must match the oldest expected transfer.
  always @(negedge clk) begin
    if (m0_wb_ack_o === 1'b1 || m1_wb_ack_o === 1'b1) begin
      sb_t e;
      check("ack_onehot", -1, 64'(m0_wb_ack_o & m1_wb_ack_o), 64'd0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_ack got m0=%b m1=%b want none", m0_wb_ack_o, m1_wb_ack_o);
      end else begin
        e = sbq.pop_front();
        check("sb_who", -1, 64'(m1_wb_ack_o), 64'(e.who));
        check("sb_dat", -1, 64'(m1_wb_ack_o ? m1_wb_dat_o : m0_wb_dat_o), 64'(e.dat));
      end
    end
  end

  initial begin
    int  n_stb;
    bit  seen;
    vec_t v;
    logic [31:0] e_adr;
    logic [35:0] e_wr;
    logic        e_we;

    reset = 1'b0;
    {m0_wb_cyc_i, m0_wb_stb_i, m1_wb_cyc_i, m1_wb_stb_i, s_wb_ack_i} = '0;
    m0_wb_we_i  = 1'b0; m0_wb_adr_i = A0; m0_wb_dat_i = W0; m0_wb_sel_i = 4'hF;
    m1_wb_we_i  = 1'b1; m1_wb_adr_i = A1; m1_wb_dat_i = W1; m1_wb_sel_i = 4'h3;
    s_wb_dat_i  = '0;

    // reset state
    add(6'b0_00_00_0, 32'h0, 9'b00_00_00_00_0);
    // single m0 read, slave acks two cycles after strobe
    add(6'b1_11_00_0, 32'h0,         9'b00_00_00_00_0);
    add(6'b1_11_00_0, 32'h0,         9'b01_11_00_00_0);
    add(6'b1_11_00_0, 32'h0,         9'b01_11_00_00_0);
    add(6'b1_11_00_1, 32'h1234_5678, 9'b01_11_10_00_0);
    add(6'b1_00_00_0, 32'h0,         9'b01_00_00_00_0);
    add(6'b1_00_00_0, 32'h0,         9'b00_00_00_00_0);
    // stray ack while idle is dropped
    add(6'b1_00_00_1, 32'h5555_5555, 9'b00_00_00_00_0);
    // tie (m1 first) then strict alternation over 6 transfers, no idle at handover
    add(6'b1_11_11_0, 32'h0, 9'b00_00_00_00_0);
    for (int t = 0; t < 6; t++) begin
      bit o;
      o = (t % 2 == 0);
      add(6'b1_11_11_1, 32'hD000_0000 + 32'(t), o ? 9'b10_11_01_00_0 : 9'b01_11_10_00_0);
      if (t == 5) add(6'b1_00_00_0, 32'h0, 9'b01_00_00_00_0);
      else        add(o ? 6'b1_11_00_0 : 6'b1_00_11_0, 32'h0, o ? 9'b10_00_00_00_0 : 9'b01_00_00_00_0);
    end
    add(6'b1_00_00_0, 32'h0, 9'b00_00_00_00_0);
    // m1 holds cyc over three strobes while m0 waits
    add(6'b1_00_11_0, 32'h0,         9'b00_00_00_00_0);
    add(6'b1_11_11_1, 32'hB000_0001, 9'b10_11_01_00_0);
    add(6'b1_11_10_0, 32'h0,         9'b10_10_00_00_0);
    add(6'b1_11_11_1, 32'hB000_0002, 9'b10_11_01_00_0);
    add(6'b1_11_10_0, 32'h0,         9'b10_10_00_00_0);
    add(6'b1_11_11_1, 32'hB000_0003, 9'b10_11_01_00_0);
    add(6'b1_11_00_0, 32'h0,         9'b10_00_00_00_0);
    add(6'b1_11_00_0, 32'h0,         9'b01_11_00_00_0);
    add(6'b1_00_00_0, 32'h0,         9'b01_00_00_00_0);
    add(6'b1_00_00_0, 32'h0,         9'b00_00_00_00_0);
    // watchdog: no ack, err on 5th strobe cycle
    add(6'b1_11_00_0, 32'h0, 9'b00_00_00_00_0);
    for (int k = 0; k < 4; k++) add(6'b1_11_00_0, 32'h0, 9'b01_11_00_00_0);
    add(6'b1_11_00_0, 32'h0, 9'b01_00_00_10_1);
    add(6'b1_00_00_0, 32'h0, 9'b00_00_00_00_1);
    // ack on exactly the 4th strobe cycle beats the watchdog
    add(6'b1_11_00_0, 32'h0, 9'b00_00_00_00_1);
    for (int k = 0; k < 3; k++) add(6'b1_11_00_0, 32'h0, 9'b01_11_00_00_1);
    add(6'b1_11_00_1, 32'hCAFE_0004, 9'b01_11_10_00_1);
    add(6'b1_00_00_0, 32'h0,         9'b01_00_00_00_1);
    add(6'b1_00_00_0, 32'h0,         9'b00_00_00_00_1);
    // reset during an m1 write, then a tie goes to m1 again
    add(6'b1_00_11_0, 32'h0, 9'b00_00_00_00_1);
    add(6'b1_00_11_0, 32'h0, 9'b10_11_00_00_1);
    add(6'b0_00_11_0, 32'h0, 9'b10_11_00_00_1);
    add(6'b0_00_11_0, 32'h0, 9'b00_00_00_00_0);
    add(6'b1_11_11_0, 32'h0, 9'b00_00_00_00_0);
    add(6'b1_11_11_0, 32'h0, 9'b10_11_00_00_0);
    add(6'b1_00_00_0, 32'h0, 9'b10_00_00_00_0);
    add(6'b1_00_00_0, 32'h0, 9'b00_00_00_00_0);

    repeat (2) @(posedge clk);

    // Apply each vector for one cycle and compare every output against the table.
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      @(posedge clk);
      #1;
      {reset, m0_wb_cyc_i, m0_wb_stb_i, m1_wb_cyc_i, m1_wb_stb_i, s_wb_ack_i} = v.in;
      s_wb_dat_i = v.dat;
      if (v.ex[4]) sbq.push_back('{1'b0, v.dat});
      if (v.ex[3]) sbq.push_back('{1'b1, v.dat});
      e_adr = (v.ex[8:7] == 2'b01) ? A0 : (v.ex[8:7] == 2'b10) ? A1 : 32'h0;
      e_wr  = (v.ex[8:7] == 2'b01) ? {W0, 4'hF} : (v.ex[8:7] == 2'b10) ? {W1, 4'h3} : 36'h0;
      e_we  = (v.ex[8:7] == 2'b10);
      #1;
      check("grant",   i, 64'(grant_o),        64'(v.ex[8:7]));
      check("s_cyc",   i, 64'(s_wb_cyc_o),     64'(v.ex[6]));
      check("s_stb",   i, 64'(s_wb_stb_o),     64'(v.ex[5]));
      check("m0_ack",  i, 64'(m0_wb_ack_o),    64'(v.ex[4]));
      check("m1_ack",  i, 64'(m1_wb_ack_o),    64'(v.ex[3]));
      check("m0_err",  i, 64'(m0_wb_err_o),    64'(v.ex[2]));
      check("m1_err",  i, 64'(m1_wb_err_o),    64'(v.ex[1]));
      check("tflag",   i, 64'(timeout_flag_o), 64'(v.ex[0]));
      check("s_adr",   i, 64'(s_wb_adr_o),     64'(e_adr));
      check("s_we",    i, 64'(s_wb_we_o),      64'(e_we));
      check("s_wdat",  i, 64'({s_wb_dat_o, s_wb_sel_o}), 64'(e_wr));
      check("rdat",    i, {m0_wb_dat_o, m1_wb_dat_o}, {v.dat, v.dat});
    end

    // Hand sequence: timeout flag starts clear, counts strobe cycles up to the abort.
    @(posedge clk);
    #1;
    check("wd_flag_pre", -2, 64'(timeout_flag_o), 64'd0);
    {reset, m0_wb_cyc_i, m0_wb_stb_i, m1_wb_cyc_i, m1_wb_stb_i, s_wb_ack_i} = 6'b1_11_00_0;
    n_stb = 0;
    seen  = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      #2;
      if (m0_wb_err_o) seen = 1'b1;
      else if (s_wb_stb_o) n_stb++;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wd_err_timeout got no m0_err in 20 cycles want err after 4 strobes");
    end else begin
      check("wd_stb_cnt",  -2, 64'(n_stb),          64'd4);
      check("wd_abort_cyc", -2, 64'(s_wb_cyc_o),    64'd0);
      check("wd_flag_set", -2, 64'(timeout_flag_o), 64'd1);
      @(posedge clk);
      #2;
      check("wd_err_once", -2, 64'(m0_wb_err_o),    64'd0);
      check("wd_idle",     -2, 64'(grant_o),        64'd0);
    end
    #1;
    {m0_wb_cyc_i, m0_wb_stb_i} = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    check("wd_flag_sticky", -2, 64'(timeout_flag_o), 64'd1);
    check("sb_left",        -2, 64'(sbq.size()),     64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
